avalon_mm_ram_slave: RTL

- Avalon-MM pipelined slave. It is the downstream consumer of the JTAG-to-memory master bridge: that bridge's master_* outputs connect directly to this block's slave_* inputs.
- Provides a word-organised on-chip RAM with byte-enable writes and a fixed, parameterised read latency.
- Throttles via waitrequest when the outstanding-read limit is reached.
- Bounds-checks byte addresses and counts protocol/range errors.

---
 rtl/avalon_mm_ram_slave_pkg.sv | 14 +
 rtl/avalon_mm_ram_slave_if.sv | 24 ++
 rtl/avalon_mm_ram_slave_read_delay_line.sv | 27 ++
 rtl/avalon_mm_ram_slave.sv | 131 +++++++++++++
 4 files changed

// File: rtl/avalon_mm_ram_slave_pkg.sv
// rtl/avalon_mm_ram_slave_pkg.sv - shared constants and read-pipeline tag type for the Avalon-MM RAM slave
package avalon_ram_pkg;

  localparam int AVS_DATA_W = 32;
  localparam int AVS_BE_W   = 4;
  localparam int ERR_CNT_W  = 16;
  localparam logic [AVS_DATA_W-1:0] AVS_FILL_WORD = 32'hDEADBEEF;

  typedef struct packed {
    logic valid;
    logic oor;
  } rd_pipe_t;

endpackage

// File: rtl/avalon_mm_ram_slave_if.sv
// rtl/avalon_mm_ram_slave_if.sv - Avalon-MM pipelined bus bundle between bridge master and RAM slave
interface avalon_mm_ram_slave_if;
  import avalon_ram_pkg::*;

  logic [AVS_DATA_W-1:0] slave_address;
  logic                  slave_read;
  logic                  slave_write;
  logic [AVS_DATA_W-1:0] slave_writedata;
  logic [AVS_BE_W-1:0]   slave_byteenable;
  logic                  slave_waitrequest;
  logic [AVS_DATA_W-1:0] slave_readdata;
  logic                  slave_readdatavalid;

  modport master (
    output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    input  slave_waitrequest, slave_readdata, slave_readdatavalid
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
    output slave_waitrequest, slave_readdata, slave_readdatavalid
  );

endinterface

// File: rtl/avalon_mm_ram_slave_read_delay_line.sv
// rtl/avalon_mm_ram_slave_read_delay_line.sv - fixed-latency tag shift register; last stage is the return strobe
module avs_read_delay_line
  import avalon_ram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  rd_pipe_t               in_tag,
  output rd_pipe_t [DEPTH-1:0]   stage,
  output logic                   ret
);

  always_ff @(posedge clk) begin
    if (clr) begin
      stage <= '0;
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign ret = stage[DEPTH-1].valid;

endmodule

// File: rtl/avalon_mm_ram_slave.sv
// rtl/avalon_mm_ram_slave.sv - Avalon-MM pipelined RAM slave with fixed read latency and error counting
// Optional sticky first-error address port enabled by AVS_RAM_STICKY_ERR_EN.
module avalon_mm_ram_slave
  import avalon_ram_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic                  clk_clk,
  input  logic                  clk_reset_reset,
  avalon_mm_ram_slave_if.slave  avs,
  output logic [ERR_CNT_W-1:0]  err_count
`ifdef AVS_RAM_STICKY_ERR_EN
  ,
  output logic [AVS_DATA_W-1:0] err_addr
`endif
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [AVS_DATA_W-1:0] mem [DEPTH];
  logic [AVS_DATA_W-1:0] dpipe [READ_LATENCY];

  logic                  rst_hold;
  logic [PEND_W-1:0]     pending;
  logic                  ret;
  logic                  wait_req;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  oor;
  logic                  err_ev;
  logic [ADDR_W-1:0]     idx;
  rd_pipe_t              in_tag;
  rd_pipe_t [READ_LATENCY-1:0] stage;

  assign idx = avs.slave_address[ADDR_W+1:2];
  assign oor = ((avs.slave_address >> (ADDR_W + 2)) != '0) || (avs.slave_address[1:0] != 2'b00);

  // A return in this cycle frees a slot, so a read at the limit is not stalled then.
  assign wait_req = rst_hold ||
                    (avs.slave_read && (pending == PEND_W'(MAX_PENDING)) && !ret);
  assign accept   = (avs.slave_read || avs.slave_write) && !wait_req;
  assign wr_acc   = accept && avs.slave_write;
  assign rd_acc   = accept && avs.slave_read && !avs.slave_write;
  assign err_ev   = accept && (oor || (avs.slave_read && avs.slave_write));

  assign in_tag.valid = rd_acc;
  assign in_tag.oor   = oor;

  always_ff @(posedge clk_clk) begin
    rst_hold <= clk_reset_reset;
  end

  always_ff @(posedge clk_clk) begin
    if (clk_reset_reset) begin
      pending <= '0;
    end else if (rd_acc && !ret) begin
      pending <= pending + PEND_W'(1);
    end else if (!rd_acc && ret) begin
      pending <= pending - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (clk_reset_reset) begin
      err_count <= '0;
    end else if (err_ev && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_acc && !oor) begin
      for (int b = 0; b < AVS_BE_W; b++) begin
        if (avs.slave_byteenable[b]) begin
          mem[idx][8*b +: 8] <= avs.slave_writedata[8*b +: 8];
        end
      end
    end
  end

  // Each data stage only moves when its tag moves, so the last stage holds between returns.
  always_ff @(posedge clk_clk) begin
    if (clk_reset_reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        dpipe[i] <= '0;
      end
    end else begin
      if (rd_acc) begin
        dpipe[0] <= oor ? AVS_FILL_WORD : mem[idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        if (stage[i-1].valid) begin
          dpipe[i] <= stage[i-1].oor ? AVS_FILL_WORD : dpipe[i-1];
        end
      end
    end
  end

  avs_read_delay_line #(
    .DEPTH (READ_LATENCY)
  ) u_delay (
    .clk    (clk_clk),
    .clr    (clk_reset_reset),
    .in_tag (in_tag),
    .stage  (stage),
    .ret    (ret)
  );

  assign avs.slave_waitrequest   = wait_req;
  assign avs.slave_readdatavalid = ret;
  assign avs.slave_readdata      = dpipe[READ_LATENCY-1];

`ifdef AVS_RAM_STICKY_ERR_EN
  logic err_seen;

  always_ff @(posedge clk_clk) begin
    if (clk_reset_reset) begin
      err_seen <= 1'b0;
      err_addr <= '0;
    end else if (err_ev && !err_seen) begin
      err_seen <= 1'b1;
      err_addr <= avs.slave_address;
    end
  end
`endif

endmodule
